// File: rtl/pwm_pkg.sv
// pwm_pkg: shared mode constants, default sizes and packed-duty slice helper for pwm_multi_gen.
`define PWM_SLICE(v, i, w) v[(i)*(w) +: (w)]
package pwm_pkg;
  localparam int MODE_EDGE = 0;
  localparam int MODE_CENTER = 1;
  localparam int DEF_CH = 4;
  localparam int DEF_WIDTH = 12;
endpackage

// File: rtl/pwm_channel_cmp.sv
// pwm_channel_cmp: one channel's active duty register, compare against the shared counter, registered output.
module pwm_channel_cmp
  import pwm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] duty_next,
  input  logic [WIDTH-1:0] cnt,
  output logic             pwm
);
  logic [WIDTH-1:0] duty;
  always_ff @(posedge clk) begin
    if (rst) begin
      duty <= '0;
      pwm  <= 1'b0;
    end else begin
      duty <= load ? duty_next : duty;
      pwm  <= en && (cnt < duty);
    end
  end
endmodule

// File: rtl/pwm_multi_gen.sv
// pwm_multi_gen: multi-channel PWM with shared period counter, double-buffered period/duty, edge or center mode.
// Optional period watchdog forcing a safe duty is built when PWM_MULTI_FAILSAFE_EN is defined.
module pwm_multi_gen
  import pwm_pkg::*;
#(
  parameter int CH         = DEF_CH,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int CENTER     = MODE_EDGE,
  parameter int RST_PERIOD = 4095,
  parameter int FS_PERIODS = 50,
  parameter int FS_DUTY    = 0
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                enable_in,
  input  logic [WIDTH-1:0]    period_in,
  input  logic [CH*WIDTH-1:0] duty_in,
  input  logic                load_in,
  output logic [CH-1:0]       pwm_out,
  output logic                period_tick_out,
  output logic                failsafe_out
);
  localparam bit IS_CENTER = CENTER == MODE_CENTER;
  logic [WIDTH-1:0] cnt, per, sh_per, peff;
  logic [CH*WIDTH-1:0] sh_duty, duty_next;
  logic up, pend, bnd, take_in, take_sh, fs_trip, duty_load;
  assign peff = (IS_CENTER && per == '0) ? WIDTH'(1) : per;
  assign bnd = enable_in && (IS_CENTER ? (cnt == '0 && up) : (cnt == per));
  assign period_tick_out = bnd;
  // Inputs bypass the shadow when idle or when the strobe lands on the boundary itself.
  assign take_in = load_in && (!enable_in || bnd);
  assign take_sh = bnd && pend && !load_in;
  assign duty_load = take_in || take_sh || fs_trip;
  assign duty_next = fs_trip ? {CH{WIDTH'(FS_DUTY)}} : take_in ? duty_in : sh_duty;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt     <= '0;
      up      <= 1'b1;
      per     <= WIDTH'(RST_PERIOD);
      pend    <= 1'b0;
      sh_per  <= '0;
      sh_duty <= '0;
    end else begin
      if (!enable_in) begin
        cnt <= '0;
        up  <= 1'b1;
      end else if (!IS_CENTER) begin
        cnt <= bnd ? '0 : cnt + 1'b1;
      end else if (up) begin
        cnt <= (cnt >= peff) ? peff - 1'b1 : cnt + 1'b1;
        up  <= (cnt >= peff) ? (peff == WIDTH'(1)) : 1'b1;
      end else begin
        cnt <= cnt - 1'b1;
        up  <= cnt == WIDTH'(1);
      end
      per     <= take_in ? period_in : take_sh ? sh_per : per;
      pend    <= (take_in || take_sh) ? 1'b0 : (load_in || pend);
      sh_per  <= load_in ? period_in : sh_per;
      sh_duty <= load_in ? duty_in : sh_duty;
    end
  end
`ifdef PWM_MULTI_FAILSAFE_EN
  logic [15:0] wd;
  logic fs;
  assign fs_trip = bnd && !load_in && wd == 16'(FS_PERIODS - 1);
  assign failsafe_out = fs;
  always_ff @(posedge clk_in) begin
    if (rst_in || load_in) begin
      wd <= '0;
      fs <= 1'b0;
    end else begin
      wd <= (bnd && wd != 16'hffff) ? wd + 1'b1 : wd;
      fs <= fs || fs_trip;
    end
  end
`else
  assign fs_trip = 1'b0;
  assign failsafe_out = 1'b0;
`endif
  for (genvar i = 0; i < CH; i++) begin : g_ch
    pwm_channel_cmp #(.WIDTH(WIDTH)) u_cmp (
      .clk      (clk_in),
      .rst      (rst_in),
      .en       (enable_in),
      .load     (duty_load),
      .duty_next(`PWM_SLICE(duty_next, i, WIDTH)),
      .cnt      (cnt),
      .pwm      (pwm_out[i])
    );
  end
endmodule

// File: tb/tb_pwm_multi_gen.sv
// tb_pwm_multi_gen: scoreboard bench driving an edge-aligned and a center-aligned instance from shared stimulus.
module tb_pwm_multi_gen;
  localparam int CH = 4;
  localparam int W = 12;
  localparam int FSN = 3;
  localparam int FSD = 2;
  typedef struct packed {
    logic [CH-1:0] pe;
    logic [CH-1:0] pc;
    logic te;
    logic tc;
    logic fe;
    logic fc;
  } exp_t;
  logic clk = 0, rst = 0, enable = 0, load = 0;
  logic [W-1:0] period = '0;
  logic [CH*W-1:0] duty = '0;
  logic [CH-1:0] pwm_e, pwm_c;
  logic tick_e, tick_c, fs_e, fs_c;
  logic [1:0] ot;
  exp_t sb[$];
  int total = 0, passed = 0;
  int m_cnt[2], m_per[2], m_sp[2], m_wd[2];
  int m_duty[2][CH], m_sd[2][CH];
  bit m_up[2], m_pend[2], m_fs[2];

  pwm_multi_gen #(.CH(CH), .WIDTH(W), .CENTER(0), .RST_PERIOD(4095), .FS_PERIODS(FSN), .FS_DUTY(FSD)) u_edge (
    .clk_in(clk), .rst_in(rst), .enable_in(enable), .period_in(period), .duty_in(duty),
    .load_in(load), .pwm_out(pwm_e), .period_tick_out(tick_e), .failsafe_out(fs_e));
  pwm_multi_gen #(.CH(CH), .WIDTH(W), .CENTER(1), .RST_PERIOD(4095), .FS_PERIODS(FSN), .FS_DUTY(FSD)) u_ctr (
    .clk_in(clk), .rst_in(rst), .enable_in(enable), .period_in(period), .duty_in(duty),
    .load_in(load), .pwm_out(pwm_c), .period_tick_out(tick_c), .failsafe_out(fs_c));

  always #5 clk = ~clk;

  function automatic logic [CH*W-1:0] pk(input int a, input int b, input int c, input int d);
    pk = {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  // Reference behaviour: one cycle of both instances, expectations queued for the following edge.
  task automatic cyc(input bit r, input bit en, input bit ld, input int p, input logic [CH*W-1:0] d);
    exp_t e;
    logic [CH-1:0] pw[2];
    logic tk[2];
    bit bnd;
    int pe;
    rst = r; enable = en; load = ld; period = p[W-1:0]; duty = d;
    for (int k = 0; k < 2; k++) begin
      pe = (k == 1 && m_per[k] == 0) ? 1 : m_per[k];
      bnd = en && (k == 0 ? m_cnt[k] == m_per[k] : (m_cnt[k] == 0 && m_up[k]));
      tk[k] = bnd;
      for (int c = 0; c < CH; c++) pw[k][c] = !r && en && (m_cnt[k] < m_duty[k][c]);
      if (r) begin
        m_cnt[k] = 0; m_up[k] = 1; m_per[k] = 4095; m_sp[k] = 0; m_pend[k] = 0; m_wd[k] = 0; m_fs[k] = 0;
        for (int c = 0; c < CH; c++) begin m_duty[k][c] = 0; m_sd[k][c] = 0; end
      end else begin
        if (ld && (bnd || !en)) begin
          m_per[k] = p;
          for (int c = 0; c < CH; c++) m_duty[k][c] = int'(d[c*W +: W]);
          m_pend[k] = 0;
        end else if (ld) begin
          m_sp[k] = p;
          for (int c = 0; c < CH; c++) m_sd[k][c] = int'(d[c*W +: W]);
          m_pend[k] = 1;
        end else if (bnd && m_pend[k]) begin
          m_per[k] = m_sp[k];
          for (int c = 0; c < CH; c++) m_duty[k][c] = m_sd[k][c];
          m_pend[k] = 0;
        end
        if (ld) begin m_wd[k] = 0; m_fs[k] = 0; end
        else if (bnd) begin
          m_wd[k]++;
`ifdef PWM_MULTI_FAILSAFE_EN
          if (m_wd[k] == FSN) begin
            m_fs[k] = 1;
            for (int c = 0; c < CH; c++) m_duty[k][c] = FSD;
          end
`endif
        end
        if (!en) begin m_cnt[k] = 0; m_up[k] = 1; end
        else if (k == 0) m_cnt[k] = bnd ? 0 : m_cnt[k] + 1;
        else if (m_up[k]) begin
          if (m_cnt[k] == pe) begin
            m_cnt[k] = pe - 1;
            m_up[k] = (pe == 1);
          end else m_cnt[k] = m_cnt[k] + 1;
        end else begin
          m_cnt[k] = m_cnt[k] - 1;
          m_up[k] = (m_cnt[k] == 0);
        end
      end
    end
    e.pe = pw[0]; e.pc = pw[1]; e.te = tk[0]; e.tc = tk[1]; e.fe = m_fs[0]; e.fc = m_fs[1];
    sb.push_back(e);
    @(negedge clk) ot = {tick_e, tick_c};
    @(posedge clk) #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      cyc(i < 2, i >= 2, 0, 0, '0);
      e = sb.pop_front(); total++;
      if ({pwm_e, pwm_c, ot, fs_e, fs_c} !== e) $display("FAIL reset cyc%0d got %h exp %h", i, {pwm_e, pwm_c, ot, fs_e, fs_c}, e);
      else passed++;
      if (i == 1) begin
        total++;
        if ({pwm_e, pwm_c, tick_e, tick_c, fs_e, fs_c} !== '0) $display("FAIL reset_zero got %h exp 0", {pwm_e, pwm_c, tick_e, tick_c, fs_e, fs_c});
        else passed++;
      end
    end
  endtask

  task automatic test_edge();
    exp_t e;
    int hi = 0, tk = 0;
    cyc(0, 0, 1, 9, pk(3, 0, 10, 15));
    e = sb.pop_front(); total++;
    if ({pwm_e, pwm_c, ot, fs_e, fs_c} !== e) $display("FAIL edge_load got %h exp %h", {pwm_e, pwm_c, ot, fs_e, fs_c}, e);
    else passed++;
    for (int i = 0; i < 30; i++) begin
      cyc(0, 1, 0, 0, '0);
      hi += int'(pwm_e[0]); tk += int'(ot[1]);
      e = sb.pop_front(); total++;
      if ({pwm_e, pwm_c, ot, fs_e, fs_c} !== e) $display("FAIL edge cyc%0d got %h exp %h", i, {pwm_e, pwm_c, ot, fs_e, fs_c}, e);
      else passed++;
    end
    total++;
    if (hi != 9 || tk != 3) $display("FAIL edge_counts got hi=%0d ticks=%0d exp hi=9 ticks=3", hi, tk);
    else passed++;
  endtask

  task automatic test_double_load();
    exp_t e;
    for (int i = 0; i < 36; i++) begin
      cyc(0, 1, i == 3 || i == 5, 9, i == 3 ? pk(2, 0, 10, 15) : pk(7, 0, 10, 15));
      e = sb.pop_front(); total++;
      if ({pwm_e, pwm_c, ot, fs_e, fs_c} !== e) $display("FAIL double_load cyc%0d got %h exp %h", i, {pwm_e, pwm_c, ot, fs_e, fs_c}, e);
      else passed++;
    end
  endtask

  task automatic test_boundary_load();
    exp_t e;
    bit hit = 0;
    int tk = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      hit = m_cnt[0] == m_per[0];
      cyc(0, 1, hit, 4, pk(2, 0, 4, 5));
      e = sb.pop_front(); total++;
      if ({pwm_e, pwm_c, ot, fs_e, fs_c} !== e) $display("FAIL bnd_load_pre cyc%0d got %h exp %h", i, {pwm_e, pwm_c, ot, fs_e, fs_c}, e);
      else passed++;
    end
    total++;
    if (!hit) $display("FAIL bnd_load_search got no boundary exp boundary within 20 cycles");
    else passed++;
    for (int i = 0; i < 15; i++) begin
      cyc(0, 1, 0, 0, '0);
      tk += int'(ot[1]);
      e = sb.pop_front(); total++;
      if ({pwm_e, pwm_c, ot, fs_e, fs_c} !== e) $display("FAIL bnd_load cyc%0d got %h exp %h", i, {pwm_e, pwm_c, ot, fs_e, fs_c}, e);
      else passed++;
    end
    total++;
    if (tk != 3) $display("FAIL bnd_load_ticks got %0d exp 3", tk);
    else passed++;
  endtask

  task automatic test_center();
    exp_t e;
    int hi = 0, tk = 0;
    cyc(0, 0, 1, 8, pk(3, 0, 8, 9));
    e = sb.pop_front(); total++;
    if ({pwm_e, pwm_c, ot, fs_e, fs_c} !== e) $display("FAIL center_load got %h exp %h", {pwm_e, pwm_c, ot, fs_e, fs_c}, e);
    else passed++;
    for (int i = 0; i < 48; i++) begin
      cyc(0, 1, 0, 0, '0);
      hi += int'(pwm_c[0]); tk += int'(ot[0]);
      e = sb.pop_front(); total++;
      if ({pwm_e, pwm_c, ot, fs_e, fs_c} !== e) $display("FAIL center cyc%0d got %h exp %h", i, {pwm_e, pwm_c, ot, fs_e, fs_c}, e);
      else passed++;
    end
    total++;
    if (hi != 15 || tk != 3) $display("FAIL center_counts got hi=%0d ticks=%0d exp hi=15 ticks=3", hi, tk);
    else passed++;
    for (int i = 0; i < 10; i++) begin
      cyc(0, i > 0, i == 0, 0, pk(1, 2, 0, 0));
      e = sb.pop_front(); total++;
      if ({pwm_e, pwm_c, ot, fs_e, fs_c} !== e) $display("FAIL center_p0 cyc%0d got %h exp %h", i, {pwm_e, pwm_c, ot, fs_e, fs_c}, e);
      else passed++;
    end
  endtask

  task automatic test_disable();
    exp_t e;
    for (int i = 0; i < 22; i++) begin
      cyc(0, i < 4 || i > 7, i == 5, 6, pk(2, 6, 7, 1));
      e = sb.pop_front(); total++;
      if ({pwm_e, pwm_c, ot, fs_e, fs_c} !== e) $display("FAIL disable cyc%0d got %h exp %h", i, {pwm_e, pwm_c, ot, fs_e, fs_c}, e);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit hit = 0;
    cyc(0, 0, 1, 9, pk(3, 3, 3, 3));
    void'(sb.pop_front());
    for (int i = 0; i < 12 && !hit; i++) begin
      cyc(0, 1, 0, 0, '0);
      void'(sb.pop_front());
      hit = m_cnt[0] == 2;
    end
    total++;
    if (pwm_e[0] !== 1'b1) $display("FAIL reset_mid_pre got %b exp 1", pwm_e[0]);
    else passed++;
    for (int i = 0; i < 12; i++) begin
      cyc(i == 0, 1, 0, 0, '0);
      e = sb.pop_front(); total++;
      if ({pwm_e, pwm_c, ot, fs_e, fs_c} !== e) $display("FAIL reset_mid cyc%0d got %h exp %h", i, {pwm_e, pwm_c, ot, fs_e, fs_c}, e);
      else passed++;
      if (i == 0) begin
        total++;
        if (pwm_e !== '0) $display("FAIL reset_mid_out got %h exp 0", pwm_e);
        else passed++;
      end
    end
  endtask

  task automatic test_failsafe();
    exp_t e;
    cyc(0, 0, 1, 4, pk(4, 4, 4, 4));
    void'(sb.pop_front());
    for (int i = 0; i < 30; i++) begin
      cyc(0, 1, i == 22, 4, pk(1, 1, 1, 1));
      e = sb.pop_front(); total++;
      if ({pwm_e, pwm_c, ot, fs_e, fs_c} !== e) $display("FAIL failsafe cyc%0d got %h exp %h", i, {pwm_e, pwm_c, ot, fs_e, fs_c}, e);
      else passed++;
      if (i == 21) begin
        total++;
`ifdef PWM_MULTI_FAILSAFE_EN
        if ({fs_e, fs_c} !== 2'b11) $display("FAIL failsafe_trip got %b exp 11", {fs_e, fs_c});
`else
        if ({fs_e, fs_c} !== 2'b00) $display("FAIL failsafe_off got %b exp 00", {fs_e, fs_c});
`endif
        else passed++;
      end
    end
    total++;
    if ({fs_e, fs_c} !== 2'b00) $display("FAIL failsafe_clear got %b exp 00", {fs_e, fs_c});
    else passed++;
  endtask

  initial begin
    @(posedge clk) #1;
    test_reset();
    test_edge();
    test_double_load();
    test_boundary_load();
    test_center();
    test_disable();
    test_reset_mid();
    test_failsafe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
